// File: rtl/hopctrl_pkg.sv
// Shared constants, FSM encoding and bit-gather helpers for the hop control word block.
package hopctrl_pkg;

    localparam int unsigned CH_MAX_BT    = 79;
    localparam int unsigned AFH_N_MIN_BT = 20;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } hop_fsm_e;

    // C word gather: even bits of BD_ADDR[8:0], MSB first.
    function automatic logic [4:0] gather_c(input logic [8:0] v);
        return {v[8], v[6], v[4], v[2], v[0]};
    endfunction

    // E word gather: odd bits of BD_ADDR[13:1], passed in as BD_ADDR[13:1].
    function automatic logic [6:0] gather_e(input logic [12:0] v);
        return {v[12], v[10], v[8], v[6], v[4], v[2], v[0]};
    endfunction

endpackage

// File: rtl/hopctrlwd_afh_if.sv
// Start/status handshake between the slot timer (master) and the hop word generator (slave).
//   calc_req  : start pulse from master
//   busy      : divider iterating
//   done_p    : F/Fprime updated this cycle
//   req_drop  : calc_req arrived while busy and was ignored
//   f_valid   : at least one result produced since reset
//   afh_n_err : AFH channel count latched at the last start was out of range
interface hopctrlwd_afh_if;
    logic calc_req;
    logic busy;
    logic done_p;
    logic req_drop;
    logic f_valid;
    logic afh_n_err;

    modport master (
        output calc_req,
        input  busy, done_p, req_drop, f_valid, afh_n_err
    );

    modport slave (
        input  calc_req,
        output busy, done_p, req_drop, f_valid, afh_n_err
    );
endinterface

// File: rtl/hop_modn_step.sv
// One restoring-division step: shift in one dividend bit, subtract the modulus if it fits.
//   r        : current partial remainder (always < modulus)
//   din      : next dividend bit, MSB first
//   modulus  : divisor
//   r_next_c : updated partial remainder (combinational)
module hop_modn_step #(
    parameter int unsigned MOD_W = 7
) (
    input  logic [MOD_W:0]   r,
    input  logic             din,
    input  logic [MOD_W-1:0] modulus,
    output logic [MOD_W:0]   r_next_c
);

    logic [MOD_W+1:0] trial;

    assign trial = {r, din};

    always_comb begin
        r_next_c = (MOD_W+1)'(trial);
        if (trial >= (MOD_W+2)'(modulus)) begin
            r_next_c = (MOD_W+1)'(trial - (MOD_W+2)'(modulus));
        end
    end

endmodule

// File: rtl/hopctrlwd_afh.sv
// Connection-state hop control word generator with a shared iterative mod unit for F and F'.
//   clk_6M, rst         : clock, synchronous active-high reset
//   ctl (slave)         : calc_req / busy / done_p / req_drop / f_valid / afh_n_err
//   conns               : connection state, gates the hop words
//   CLK, BD_ADDR        : piconet clock and device address
//   regi_AFH_N          : AFH used-channel count
//   X, Y1, Y2, A..E     : combinational kernel words
//   F, Fprime           : registered mod results, gated by conns
module hopctrlwd_afh
    import hopctrl_pkg::*;
#(
    parameter int unsigned CLK_W     = 28,
    parameter int unsigned DIV_W     = CLK_W - 3,
    parameter int unsigned MOD_W     = 7,
    parameter int unsigned CH_MAX    = CH_MAX_BT,
    parameter int unsigned AFH_N_MIN = AFH_N_MIN_BT
) (
    input  logic             clk_6M,
    input  logic             rst,
    hopctrlwd_afh_if.slave   ctl,
    input  logic             conns,
    input  logic [CLK_W-1:0] CLK,
    input  logic [27:0]      BD_ADDR,
    input  logic [MOD_W-1:0] regi_AFH_N,
    output logic [4:0]       X,
    output logic             Y1,
    output logic [5:0]       Y2,
    output logic [4:0]       A,
    output logic [3:0]       B,
    output logic [4:0]       C,
    output logic [8:0]       D,
    output logic [6:0]       E,
    output logic [MOD_W-1:0] F,
    output logic [MOD_W-1:0] Fprime
);

    localparam int unsigned CNT_W = $clog2(DIV_W);
    localparam logic [MOD_W-1:0] CH_MAX_L = MOD_W'(CH_MAX);
    localparam logic [MOD_W-1:0] N_MIN_L  = MOD_W'(AFH_N_MIN);

    hop_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [MOD_W-1:0] n_q, n_d;
    logic [MOD_W:0]   rem0_q, rem0_d, rem1_q, rem1_d;
    logic [MOD_W:0]   step0_c, step1_c;
    logic [MOD_W-1:0] f_q, f_d, fp_q, fp_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             fval_q, fval_d, nerr_q, nerr_d;
    logic             n_ok_c;
    logic             unused_clk0;

    assign unused_clk0 = CLK[0];

    // Kernel words, zero outside a connection
    assign X  = CLK[6:2] & {5{conns}};
    assign Y1 = CLK[1] & conns;
    assign Y2 = {CLK[1], 5'b0} & {6{conns}};
    assign A  = (BD_ADDR[27:23] ^ CLK[25:21]) & {5{conns}};
    assign B  = BD_ADDR[22:19] & {4{conns}};
    assign C  = (gather_c(BD_ADDR[8:0]) ^ CLK[20:16]) & {5{conns}};
    assign D  = (BD_ADDR[18:10] ^ CLK[15:7]) & {9{conns}};
    assign E  = gather_e(BD_ADDR[13:1]) & {7{conns}};

    assign F      = f_q & {MOD_W{conns}};
    assign Fprime = fp_q & {MOD_W{conns}};

    assign ctl.busy      = busy_q;
    assign ctl.done_p    = done_q;
    assign ctl.f_valid   = fval_q;
    assign ctl.afh_n_err = nerr_q;
    // Drop indication is same-cycle with the offending request
    assign ctl.req_drop  = ctl.calc_req & busy_q;

    assign n_ok_c = (regi_AFH_N >= N_MIN_L) && (regi_AFH_N <= CH_MAX_L);

    // Lane 0: fixed basic-hop modulus; lane 1: latched AFH modulus
    hop_modn_step #(.MOD_W(MOD_W)) u_step_f (
        .r        (rem0_q),
        .din      (div_q[cnt_q]),
        .modulus  (CH_MAX_L),
        .r_next_c (step0_c)
    );

    hop_modn_step #(.MOD_W(MOD_W)) u_step_fp (
        .r        (rem1_q),
        .din      (div_q[cnt_q]),
        .modulus  (n_q),
        .r_next_c (step1_c)
    );

    // State and datapath registers
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            n_q     <= '0;
            rem0_q  <= '0;
            rem1_q  <= '0;
            f_q     <= '0;
            fp_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fval_q  <= 1'b0;
            nerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            n_q     <= n_d;
            rem0_q  <= rem0_d;
            rem1_q  <= rem1_d;
            f_q     <= f_d;
            fp_q    <= fp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fval_q  <= fval_d;
            nerr_q  <= nerr_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        n_d     = n_q;
        rem0_d  = rem0_q;
        rem1_d  = rem1_q;
        f_d     = f_q;
        fp_d    = fp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fval_d  = fval_q;
        nerr_d  = nerr_q;

        case (state_q)
            IDLE: begin
                if (ctl.calc_req) begin
                    state_d = RUN;
                    div_d   = {CLK[CLK_W-1:7], 4'b0};
                    n_d     = n_ok_c ? regi_AFH_N : CH_MAX_L;
                    nerr_d  = !n_ok_c;
                    rem0_d  = '0;
                    rem1_d  = '0;
                    cnt_d   = CNT_W'(DIV_W - 1);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                rem0_d = step0_c;
                rem1_d = step1_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    f_d     = step0_c[MOD_W-1:0];
                    fp_d    = step1_c[MOD_W-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    fval_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hopctrlwd_afh.sv
module tb_hopctrlwd_afh;

    logic        clk_6M = 1'b0;
    logic        rst;
    logic        conns;
    logic [27:0] CLK;
    logic [27:0] BD_ADDR;
    logic [6:0]  regi_AFH_N;
    logic [4:0]  X;
    logic        Y1;
    logic [5:0]  Y2;
    logic [4:0]  A;
    logic [3:0]  B;
    logic [4:0]  C;
    logic [8:0]  D;
    logic [6:0]  E;
    logic [6:0]  F;
    logic [6:0]  Fprime;

    int checks   = 0;
    int failures = 0;

    hopctrlwd_afh_if ctl();

    hopctrlwd_afh dut (
        .clk_6M     (clk_6M),
        .rst        (rst),
        .ctl        (ctl),
        .conns      (conns),
        .CLK        (CLK),
        .BD_ADDR    (BD_ADDR),
        .regi_AFH_N (regi_AFH_N),
        .X          (X),
        .Y1         (Y1),
        .Y2         (Y2),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .F          (F),
        .Fprime     (Fprime)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done_p; check latency and results.
    task automatic run_calc(input string tag, input logic [20:0] hi, input logic [6:0] n,
                            input logic [6:0] exp_f, input logic [6:0] exp_fp,
                            input logic exp_err);
        int lat;
        CLK          = {hi, 7'h2A};
        regi_AFH_N   = n;
        ctl.calc_req = 1'b1;
        tick();
        ctl.calc_req = 1'b0;
        chk({tag, "_busy"}, 64'(ctl.busy), 64'd1);
        lat = 0;
        while (ctl.done_p !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd25);
        chk({tag, "_F"}, 64'(F), 64'(exp_f));
        chk({tag, "_Fp"}, 64'(Fprime), 64'(exp_fp));
        chk({tag, "_err"}, 64'(ctl.afh_n_err), 64'(exp_err));
        chk({tag, "_fval"}, 64'(ctl.f_valid), 64'd1);
        chk({tag, "_busy_end"}, 64'(ctl.busy), 64'd0);
    endtask

    initial begin
        int dones;

        rst          = 1'b1;
        conns        = 1'b1;
        CLK          = '0;
        BD_ADDR      = '0;
        regi_AFH_N   = 7'd20;
        ctl.calc_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", 64'(ctl.busy), 64'd0);
        chk("rst_done", 64'(ctl.done_p), 64'd0);
        chk("rst_drop", 64'(ctl.req_drop), 64'd0);
        chk("rst_fval", 64'(ctl.f_valid), 64'd0);
        chk("rst_err", 64'(ctl.afh_n_err), 64'd0);
        chk("rst_F", 64'(F), 64'd0);
        chk("rst_Fp", 64'(Fprime), 64'd0);
        rst = 1'b0;
        tick();

        // 16 mod 79 = 16, 16 mod 20 = 16
        run_calc("c1", 21'd1, 7'd20, 7'd16, 7'd16, 1'b0);
        // 80 mod 79 = 1, 80 mod 37 = 6
        run_calc("c5", 21'd5, 7'd37, 7'd1, 7'd6, 1'b0);
        // (2^25-16) mod 79 = 35
        run_calc("cmax", 21'h1FFFFF, 7'd79, 7'd35, 7'd35, 1'b0);
        // Illegal N falls back to 79
        run_calc("nlow", 21'h1FFFFF, 7'd10, 7'd35, 7'd35, 1'b1);
        // Upper illegal N also falls back
        run_calc("nhigh", 21'd5, 7'd80, 7'd1, 7'd1, 1'b1);

        // Request while busy is dropped; mid-run input changes ignored
        CLK          = {21'd5, 7'h00};
        regi_AFH_N   = 7'd37;
        ctl.calc_req = 1'b1;
        tick();
        ctl.calc_req = 1'b0;
        tick();
        tick();
        CLK          = {21'd1, 7'h00};
        regi_AFH_N   = 7'd20;
        ctl.calc_req = 1'b1;
        #1;
        chk("drop_pulse", 64'(ctl.req_drop), 64'd1);
        tick();
        ctl.calc_req = 1'b0;
        #1;
        chk("drop_clear", 64'(ctl.req_drop), 64'd0);
        dones = 0;
        for (int i = 3; i < 40; i++) begin
            tick();
            if (ctl.done_p === 1'b1) begin
                dones++;
                chk("drop_lat", 64'(i + 1), 64'd25);
            end
        end
        chk("drop_ndone", 64'(dones), 64'd1);
        chk("drop_F", 64'(F), 64'd1);
        chk("drop_Fp", 64'(Fprime), 64'd6);

        // Reset mid-computation aborts it
        CLK          = {21'd1, 7'h00};
        regi_AFH_N   = 7'd20;
        ctl.calc_req = 1'b1;
        tick();
        ctl.calc_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(ctl.busy), 64'd0);
        chk("abort_F", 64'(F), 64'd0);
        chk("abort_Fp", 64'(Fprime), 64'd0);
        chk("abort_fval", 64'(ctl.f_valid), 64'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ctl.done_p === 1'b1) dones++;
        end
        chk("abort_ndone", 64'(dones), 64'd0);
        run_calc("post", 21'd5, 7'd37, 7'd1, 7'd6, 1'b0);

        // conns=0 forces every hop word to zero
        conns   = 1'b0;
        CLK     = 28'hABCDEF3;
        BD_ADDR = 28'h1234567;
        #1;
        chk("off_words", 64'({X, Y1, Y2, A, B, C, D, E}), 64'd0);
        chk("off_F", 64'(F), 64'd0);
        chk("off_Fp", 64'(Fprime), 64'd0);
        conns = 1'b1;
        #1;
        chk("on_F", 64'(F), 64'd1);
        chk("on_Fp", 64'(Fprime), 64'd6);

        // Address-only words
        BD_ADDR = 28'hFFFFFFF;
        CLK     = 28'h0;
        #1;
        chk("w_A", 64'(A), 64'd31);
        chk("w_B", 64'(B), 64'd15);
        chk("w_C", 64'(C), 64'd31);
        chk("w_D", 64'(D), 64'd511);
        chk("w_E", 64'(E), 64'd127);
        chk("w_X", 64'(X), 64'd0);
        chk("w_Y1", 64'(Y1), 64'd0);
        chk("w_Y2", 64'(Y2), 64'd0);

        // Clock-only words
        BD_ADDR = 28'h0;
        CLK     = 28'h3E000FE;
        #1;
        chk("c_X", 64'(X), 64'd31);
        chk("c_Y1", 64'(Y1), 64'd1);
        chk("c_Y2", 64'(Y2), 64'd32);
        chk("c_A", 64'(A), 64'd31);
        chk("c_C", 64'(C), 64'd0);
        chk("c_D", 64'(D), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
